// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel/line counters plus registered syncs, display
// enable and line/frame strobes, all cycle-aligned with the DrawX/DrawY they describe.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic       line_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 2 || V_TOTAL < 1) begin : g_bad_totals
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit a 10-bit counter");
        end
    endgenerate

    // Thresholds kept 11 bits wide so an end-of-range of exactly 1024 still compares correctly.
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] nx, ny;
    logic       nhs, nvs, nblank, nframe, nline;

    always_comb begin
        nx = DrawX + 10'd1;
        ny = DrawY;
        if (DrawX == H_LAST) begin
            nx = 10'd0;
            ny = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
        end
    end

    // Decode from the next-state counters so the registered flags land with their pixel.
    always_comb begin
        nhs    = !(({1'b0, nx} >= HS_START) && ({1'b0, nx} < HS_END));
        nvs    = !(({1'b0, ny} >= VS_START) && ({1'b0, ny} < VS_END));
        nblank = ({1'b0, nx} < H_VIS) && ({1'b0, ny} < V_VIS);
        nline  = (nx == 10'd0);
        nframe = (nx == 10'd0) && (ny == 10'd0);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            DrawX       <= nx;
            DrawY       <= ny;
            hs          <= nhs;
            vs          <= nvs;
            blank       <= nblank;
            frame_start <= nframe;
            line_start  <= nline;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: stimulus pushes expected raster state per cycle for a default-timing
// instance and a shrunken one (320-wide line, 19-line frame); a negedge monitor pops and compares.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       fs;
        logic       ls;
    } vo_t;

    typedef struct {
        int  k;
        bit  rs;
        bit  ph;
        vo_t v;
    } exp_t;

    typedef struct {
        bit  b;
        int  k;
        vo_t v;
    } dir_t;

    logic       vga_clk = 1'b0;
    logic       reset;
    logic [9:0] ax, ay, bx, by;
    logic       ahs, avs, abl, afs, als;
    logic       bhs, bvs, bbl, bfs, bls;

    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    dir_t dir_tab[$];

    int   k;
    bit   rs;
    bit   phase;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen dut_a (
        .vga_clk(vga_clk), .reset(reset), .DrawX(ax), .DrawY(ay), .hs(ahs), .vs(avs),
        .blank(abl), .frame_start(afs), .line_start(als)
    );

    vga_timing_gen #(
        .H_VISIBLE(320), .H_FRONT(8), .H_SYNC(48), .H_BACK(24),
        .V_VISIBLE(12),  .V_FRONT(2), .V_SYNC(2),  .V_BACK(3)
    ) dut_b (
        .vga_clk(vga_clk), .reset(reset), .DrawX(bx), .DrawY(by), .hs(bhs), .vs(bvs),
        .blank(bbl), .frame_start(bfs), .line_start(bls)
    );

    // Reference: position is the elapsed-pixel index folded by division, not a counter chain.
    function automatic vo_t model(input int hv, hf, hsw, hb, vv, vf, vsw, vb, input int kk, input bit r);
        vo_t o;
        int  ht, vt, x, y;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (r) begin
            o = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, blank: 1'b0, fs: 1'b0, ls: 1'b0};
        end else begin
            x = kk % ht;
            y = (kk / ht) % vt;
            o.x     = 10'(x);
            o.y     = 10'(y);
            o.hs    = !(x >= hv + hf && x < hv + hf + hsw);
            o.vs    = !(y >= vv + vf && y < vv + vf + vsw);
            o.blank = (x < hv) && (y < vv);
            o.fs    = (x == 0) && (y == 0);
            o.ls    = (x == 0);
        end
        return o;
    endfunction

    task automatic add_dir(input bit b, input int kk, input int x, input int y,
                           input bit h, input bit v, input bit bl, input bit f, input bit l);
        dir_t d;
        d.b = b;
        d.k = kk;
        d.v = '{x: 10'(x), y: 10'(y), hs: h, vs: v, blank: bl, fs: f, ls: l};
        dir_tab.push_back(d);
    endtask

    task automatic compare(input string nm, input int kk, input vo_t got, input vo_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s k=%0d got x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b ls=%b want x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b ls=%b",
                     nm, kk, got.x, got.y, got.hs, got.vs, got.blank, got.fs, got.ls,
                     want.x, want.y, want.hs, want.vs, want.blank, want.fs, want.ls);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic cyc(input bit r);
        @(posedge vga_clk);
        if (!reset) begin
            k++;
            rs = 1'b0;
        end
        #3;
        reset = r;
        if (r) begin
            k  = 0;
            rs = 1'b1;
        end
        qa.push_back('{k: k, rs: rs, ph: phase, v: model(640, 16, 96, 48, 480, 10, 2, 33, k, rs)});
        qb.push_back('{k: k, rs: rs, ph: phase, v: model(320, 8, 48, 24, 12, 2, 2, 3, k, rs)});
    endtask

    // Monitor: per-cycle scoreboard compare, directed vectors, alignment and strobe spacing.
    int cyc_n   = 0;
    int last_ls = -1;
    int last_fs = -1;

    always @(negedge vga_clk) begin
        exp_t e;
        vo_t  got;
        cyc_n++;
        if (qa.size() > 0) begin
            e   = qa.pop_front();
            got = '{x: ax, y: ay, hs: ahs, vs: avs, blank: abl, fs: afs, ls: als};
            compare("dut_a", e.k, got, e.v);
            if (e.ph && !e.rs)
                foreach (dir_tab[i])
                    if (!dir_tab[i].b && dir_tab[i].k == e.k) compare("dir_a", e.k, got, dir_tab[i].v);
            if (!e.rs)
                check_int("align_a", int'(abl), int'(ax < 10'd640 && ay < 10'd480));
            if (e.rs) last_ls = -1;
            else if (als) begin
                if (last_ls >= 0) check_int("line_period_a", cyc_n - last_ls, 800);
                last_ls = cyc_n;
            end
        end
        if (qb.size() > 0) begin
            e   = qb.pop_front();
            got = '{x: bx, y: by, hs: bhs, vs: bvs, blank: bbl, fs: bfs, ls: bls};
            compare("dut_b", e.k, got, e.v);
            if (e.ph && !e.rs)
                foreach (dir_tab[i])
                    if (dir_tab[i].b && dir_tab[i].k == e.k) compare("dir_b", e.k, got, dir_tab[i].v);
            if (e.rs) last_fs = -1;
            else if (bfs) begin
                if (last_fs >= 0) check_int("frame_period_b", cyc_n - last_fs, 7600);
                last_fs = cyc_n;
            end
        end
    end

    initial begin
        reset = 1'b1;
        k     = 0;
        rs    = 1'b1;
        phase = 1'b0;
        // default instance: first edges, visible edge, hsync edges, line wrap
        add_dir(0, 1,   1,   0, 1, 1, 1, 0, 0);
        add_dir(0, 639, 639, 0, 1, 1, 1, 0, 0);
        add_dir(0, 640, 640, 0, 1, 1, 0, 0, 0);
        add_dir(0, 655, 655, 0, 1, 1, 0, 0, 0);
        add_dir(0, 656, 656, 0, 0, 1, 0, 0, 0);
        add_dir(0, 751, 751, 0, 0, 1, 0, 0, 0);
        add_dir(0, 752, 752, 0, 1, 1, 0, 0, 0);
        add_dir(0, 799, 799, 0, 1, 1, 0, 0, 0);
        add_dir(0, 800, 0,   1, 1, 1, 1, 0, 1);
        // shrunken instance: hsync 328..375, wrap at 399, vsync lines 14..15, frame wrap
        add_dir(1, 327,  327, 0,  1, 1, 0, 0, 0);
        add_dir(1, 328,  328, 0,  0, 1, 0, 0, 0);
        add_dir(1, 375,  375, 0,  0, 1, 0, 0, 0);
        add_dir(1, 376,  376, 0,  1, 1, 0, 0, 0);
        add_dir(1, 399,  399, 0,  1, 1, 0, 0, 0);
        add_dir(1, 400,  0,   1,  1, 1, 1, 0, 1);
        add_dir(1, 4719, 319, 11, 1, 1, 1, 0, 0);
        add_dir(1, 4800, 0,   12, 1, 1, 0, 0, 1);
        add_dir(1, 5599, 399, 13, 1, 1, 0, 0, 0);
        add_dir(1, 5600, 0,   14, 1, 0, 0, 0, 1);
        add_dir(1, 6399, 399, 15, 1, 0, 0, 0, 0);
        add_dir(1, 6400, 0,   16, 1, 1, 0, 0, 1);
        add_dir(1, 7599, 399, 18, 1, 1, 0, 0, 0);
        add_dir(1, 7600, 0,   0,  1, 1, 1, 1, 1);
        add_dir(1, 15200, 0,  0,  1, 1, 1, 1, 1);

        repeat (3)    cyc(1'b1);
        repeat (1900) cyc(1'b0);
        repeat (2)    cyc(1'b1);   // mid-line reset, sampled before any edge
        phase = 1'b1;
        repeat (15400) cyc(1'b0);
        @(negedge vga_clk);
        @(negedge vga_clk);
        check_int("queue_a_drained", qa.size(), 0);
        check_int("queue_b_drained", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing on the pixel clock: horizontal/vertical counters, active-low syncs, and a display-enable.
- Sits directly upstream of every tile/sprite mapper. It drives DrawX/DrawY and blank (high = visible pixel) that the mappers consume, and hs/vs to the connector.
- Also supplies per-frame and per-line strobes for game-logic updates.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- vga_clk  in  1  pixel clock (25 MHz nominal)
- reset  in  1  asynchronous, active-high reset
- DrawX  out  10  horizontal counter, 0..H_TOTAL-1
- DrawY  out  10  vertical counter, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank  out  1  display enable: 1 = visible pixel, 0 = blanking
- frame_start  out  1  one-cycle pulse, high while DrawX=0 and DrawY=0
- line_start  out  1  one-cycle pulse, high while DrawX=0

Behaviour:
- Derived totals: H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525. Both must fit in 10 bits; elaboration fails otherwise.
- Reset is asynchronous, active-high, one clock domain (vga_clk); reset is asynchronous and active-high.
- Reset values: DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_start=0, line_start=0.
- Counter step, every rising vga_clk edge when not in reset:
  - If DrawX = H_TOTAL-1: DrawX wraps to 0, and DrawY increments, or wraps to 0 if DrawY = V_TOTAL-1.
  - Otherwise DrawX increments and DrawY holds.
- All of hs, vs, blank, frame_start and line_start are registered. Each is decoded from the next-state counter value and loaded on the same edge as the counters. They are therefore cycle-aligned with the DrawX/DrawY they describe, with zero relative latency and no combinational path to the outputs.
- Decode, with (nx, ny) as the next-state counters:
  - hs = 0 iff H_VISIBLE+H_FRONT <= nx < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vs = 0 iff V_VISIBLE+V_FRONT <= ny < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491. vs changes on the line boundary when nx=0, and is held for whole lines.
  - blank = 1 iff nx < H_VISIBLE and ny < V_VISIBLE.
  - line_start = (nx == 0).
  - frame_start = (nx == 0 and ny == 0).
- Because blank is forced to 0 in reset, pixel (0,0) of the first frame after reset is blanked, and frame_start is not asserted for that first frame. Every subsequent frame is fully regular.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously). After release, counting restarts from (0,0) on the first edge, so the first edge after release produces DrawX=1, DrawY=0, blank=1.
- Simultaneous wrap at (799,524): both counters go to 0, and frame_start and line_start assert on the same cycle.
- Frame period is exactly H_TOTAL*V_TOTAL = 420000 clocks. hs period is 800 clocks with 96 low; vs period is 420000 clocks with 1600 low.

Test Plan:
- Reset: assert reset mid-count at (300,200) -> outputs 0,0 / hs=1 / vs=1 / blank=0 with no clock edge. Release -> next edge gives DrawX=1, DrawY=0, blank=1.
- Line timing: run one line from DrawX=0 -> blank high for DrawX 0..639 and low for 640..799; hs low exactly for DrawX 656..751; line_start high only at DrawX=0; DrawY increments on the edge where DrawX 799 -> 0.
- Frame timing: run 2 full frames -> blank never high for DrawY >= 480; vs low exactly for DrawY 490..491 across all 800 columns of each line; frame_start pulses exactly once per frame, 420000 clocks apart.
- Wrap corner: at DrawX=799, DrawY=524 -> next cycle DrawX=0, DrawY=0, frame_start=1, line_start=1, blank=1, hs=1, vs=1.
- Alignment check with a downstream mapper model: sample blank, DrawX and DrawY on the same edge -> blank=1 iff (DrawX<640 and DrawY<480) on every cycle of a frame, except the first post-reset cycle.
- Parameter override: H_VISIBLE=320, H_FRONT=8, H_SYNC=48, H_BACK=24 -> H_TOTAL=400; hs low for DrawX 328..375; DrawX wraps at 399.
